// File: rtl/mfi_ld_check_harness.sv
// mfi_ld_check_harness
// Retirement checker for the LD instruction on the core's MFI port. Passes the
// stimulus stream and reset through to the core, counts cycles since reset
// release, and compares each qualifying LD retirement against its architectural
// result. check_hit / check_fail are sticky until reset.

module mfi_ld_check_harness #(
    parameter int XLEN        = 32,
    parameter int RADDR_W     = 4,
    parameter int CHECK_LIMIT = 20
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               inst_valid,
    input  logic [31:0]        inst,
    output logic               core_reset_n,
    output logic               core_inst_valid,
    output logic [31:0]        core_inst,
    input  logic               mfi_valid,
    input  logic [XLEN-1:0]    mfi_order,
    input  logic [31:0]        mfi_inst,
    input  logic               mfi_trap,
    input  logic [RADDR_W-1:0] mfi_src1_addr,
    input  logic [XLEN-1:0]    mfi_src1_rdata,
    input  logic [RADDR_W-1:0] mfi_src2_addr,
    input  logic [XLEN-1:0]    mfi_src2_rdata,
    input  logic [RADDR_W-1:0] mfi_dest_addr,
    input  logic [XLEN-1:0]    mfi_dest_wdata,
    input  logic [XLEN-1:0]    mfi_pc_rdata,
    input  logic [XLEN-1:0]    mfi_pc_wdata,
    input  logic [XLEN-1:0]    mfi_mem_addr,
    input  logic [XLEN-1:0]    mfi_mem_rdata,
    output logic [7:0]         cycle_reg,
    output logic               check_hit,
    output logic               check_fail
);

    localparam logic [3:0] OP_LD    = 4'b0100;
    localparam logic [7:0] LIMIT    = 8'(CHECK_LIMIT);
    localparam logic [7:0] CYC_MAX  = 8'hFF;

    // Sign-extend the 16-bit LD offset to the datapath width.
    function automatic logic [XLEN-1:0] sext_imm(input logic signed [15:0] imm);
        return {{(XLEN-16){imm[15]}}, imm};
    endfunction

    logic [RADDR_W-1:0] rd_p0;
    logic [RADDR_W-1:0] rs1_p0;
    logic signed [15:0] imm_p0;
    logic [XLEN-1:0]    ea_p0;
    logic [XLEN-1:0]    wdata_exp_p0;
    logic               q_p0;
    logic               err_p0;
    logic [XLEN-1:0]    last_order_p1;

    // rs2 and inst[19:16] carry no meaning for LD.
    logic unused_bits;
    assign unused_bits = ^{mfi_src2_addr, mfi_src2_rdata, mfi_inst[19:16]};

    assign core_reset_n    = reset_n;
    assign core_inst_valid = inst_valid;
    assign core_inst       = inst;

    assign rd_p0  = mfi_inst[27:24];
    assign rs1_p0 = mfi_inst[23:20];
    assign imm_p0 = mfi_inst[15:0];

    // Qualify the retirement and evaluate every LD rule in the same cycle.
    always_comb begin
        q_p0         = mfi_valid & ~mfi_trap & (mfi_inst[31:28] == OP_LD)
                       & (cycle_reg <= LIMIT) & reset_n;
        ea_p0        = mfi_src1_rdata + sext_imm(imm_p0);
        wdata_exp_p0 = (rd_p0 == '0) ? '0 : mfi_mem_rdata;
        err_p0       = (mfi_dest_addr != rd_p0)
                     | (mfi_src1_addr != rs1_p0)
                     | (mfi_mem_addr != ea_p0)
                     | (mfi_dest_wdata != wdata_exp_p0)
                     | (mfi_pc_wdata != mfi_pc_rdata + XLEN'(4))
                     | (check_hit & (mfi_order <= last_order_p1));
    end

    // Cycle counter and sticky verdict flags; reset wins over a same-cycle retirement.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cycle_reg  <= '0;
            check_hit  <= 1'b0;
            check_fail <= 1'b0;
        end else begin
            if (cycle_reg != CYC_MAX)
                cycle_reg <= cycle_reg + 8'd1;
            if (q_p0)
                check_hit <= 1'b1;
            if (q_p0 && err_p0)
                check_fail <= 1'b1;
        end
    end

    // Order of the most recent checked retirement; only consulted once check_hit is set.
    always_ff @(posedge clock) begin
        if (q_p0)
            last_order_p1 <= mfi_order;
    end

endmodule

// File: tb/tb_mfi_ld_check_harness.sv
// Bench for mfi_ld_check_harness: directed scenarios followed by randomized
// retirement traffic, compared against an arithmetic reference model.

module tb_mfi_ld_check_harness;

    logic        clock;
    logic        reset_n;
    logic        inst_valid;
    logic [31:0] inst;
    logic        core_reset_n;
    logic        core_inst_valid;
    logic [31:0] core_inst;
    logic        mfi_valid;
    logic [31:0] mfi_order;
    logic [31:0] mfi_inst;
    logic        mfi_trap;
    logic [3:0]  mfi_src1_addr;
    logic [31:0] mfi_src1_rdata;
    logic [3:0]  mfi_src2_addr;
    logic [31:0] mfi_src2_rdata;
    logic [3:0]  mfi_dest_addr;
    logic [31:0] mfi_dest_wdata;
    logic [31:0] mfi_pc_rdata;
    logic [31:0] mfi_pc_wdata;
    logic [31:0] mfi_mem_addr;
    logic [31:0] mfi_mem_rdata;
    logic [7:0]  cycle_reg;
    logic        check_hit;
    logic        check_fail;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int          m_cycle;
    bit          m_hit;
    bit          m_fail;
    int unsigned m_last;
    int unsigned order_ctr;

    mfi_ld_check_harness #(.XLEN(32), .RADDR_W(4), .CHECK_LIMIT(20)) dut (
        .clock(clock), .reset_n(reset_n), .inst_valid(inst_valid), .inst(inst),
        .core_reset_n(core_reset_n), .core_inst_valid(core_inst_valid), .core_inst(core_inst),
        .mfi_valid(mfi_valid), .mfi_order(mfi_order), .mfi_inst(mfi_inst), .mfi_trap(mfi_trap),
        .mfi_src1_addr(mfi_src1_addr), .mfi_src1_rdata(mfi_src1_rdata),
        .mfi_src2_addr(mfi_src2_addr), .mfi_src2_rdata(mfi_src2_rdata),
        .mfi_dest_addr(mfi_dest_addr), .mfi_dest_wdata(mfi_dest_wdata),
        .mfi_pc_rdata(mfi_pc_rdata), .mfi_pc_wdata(mfi_pc_wdata),
        .mfi_mem_addr(mfi_mem_addr), .mfi_mem_rdata(mfi_mem_rdata),
        .cycle_reg(cycle_reg), .check_hit(check_hit), .check_fail(check_fail)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Architectural LD rules, evaluated directly from the retirement fields.
    function automatic bit ld_violates();
        int unsigned rd, rs1, want_addr, want_wdata;
        rd         = (mfi_inst >> 24) & 32'hF;
        rs1        = (mfi_inst >> 20) & 32'hF;
        want_addr  = mfi_src1_rdata + 32'($signed(mfi_inst[15:0]));
        want_wdata = (rd == 0) ? 0 : mfi_mem_rdata;
        return (mfi_dest_addr != rd) || (mfi_src1_addr != rs1) ||
               (mfi_mem_addr != want_addr) || (mfi_dest_wdata != want_wdata) ||
               (mfi_pc_wdata != mfi_pc_rdata + 4) ||
               (m_hit && mfi_order <= m_last);
    endfunction

    // Advance one clock: predict from the inputs present before the edge, then compare after it.
    task automatic step();
        bit q, e;
        chk("core_reset_n", {31'd0, core_reset_n}, {31'd0, reset_n});
        chk("core_inst_valid", {31'd0, core_inst_valid}, {31'd0, inst_valid});
        chk("core_inst", core_inst, inst);
        q = reset_n && mfi_valid && !mfi_trap && (mfi_inst[31:28] == 4'b0100) && (m_cycle <= 20);
        e = ld_violates();
        if (!reset_n) begin
            m_cycle = 0; m_hit = 0; m_fail = 0;
        end else begin
            if (q) begin
                if (e) m_fail = 1;
                m_hit  = 1;
                m_last = mfi_order;
            end
            m_cycle = (m_cycle >= 255) ? 255 : m_cycle + 1;
        end
        @(posedge clock);
        #1;
        chk("cycle_reg", {24'd0, cycle_reg}, 32'(m_cycle));
        chk("check_hit", {31'd0, check_hit}, {31'd0, m_hit});
        chk("check_fail", {31'd0, check_fail}, {31'd0, m_fail});
    endtask

    task automatic idle_mfi();
        mfi_valid = 0; mfi_trap = 0; mfi_inst = 0; mfi_order = 0;
        mfi_src1_addr = 0; mfi_src1_rdata = 0; mfi_src2_addr = 0; mfi_src2_rdata = 0;
        mfi_dest_addr = 0; mfi_dest_wdata = 0; mfi_pc_rdata = 0; mfi_pc_wdata = 0;
        mfi_mem_addr = 0; mfi_mem_rdata = 0;
    endtask

    // Present a fully consistent LD retirement.
    task automatic put_ld(input logic [3:0] rd, input logic [3:0] rs1, input logic [15:0] imm,
                          input logic [31:0] src1, input logic [31:0] memr, input logic [31:0] pc);
        mfi_valid      = 1;
        mfi_trap       = 0;
        mfi_inst       = {4'b0100, rd, rs1, 4'($urandom_range(0, 15)), imm};
        order_ctr      = order_ctr + 1;
        mfi_order      = order_ctr;
        mfi_src1_addr  = rs1;
        mfi_src1_rdata = src1;
        mfi_src2_addr  = 4'($urandom);
        mfi_src2_rdata = $urandom;
        mfi_dest_addr  = rd;
        mfi_mem_rdata  = memr;
        mfi_dest_wdata = (rd == 0) ? 32'd0 : memr;
        mfi_mem_addr   = src1 + {{16{imm[15]}}, imm};
        mfi_pc_rdata   = pc;
        mfi_pc_wdata   = pc + 4;
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 0;
        for (int i = 0; i < cycles; i++) step();
        reset_n = 1;
        order_ctr = 0;
    endtask

    initial begin
        reset_n = 0; inst_valid = 0; inst = 0;
        m_cycle = 0; m_hit = 0; m_fail = 0; m_last = 0; order_ctr = 0;
        idle_mfi();
        #2;

        // 1: reset, count up, saturate
        do_reset(2);
        for (int i = 0; i < 300; i++) begin
            inst_valid = 1'($urandom); inst = $urandom;
            step();
        end
        chk("cycle_sat", {24'd0, cycle_reg}, 32'd255);
        step();
        chk("cycle_hold", {24'd0, cycle_reg}, 32'd255);

        // 2: clean LD, rd=0
        do_reset(1);
        put_ld(4'd0, 4'd6, 16'h0DEE, 32'h1000_0FF7, 32'hDEAD_BEEF, 32'd0);
        mfi_inst = 32'h4061_0DEE;
        chk("t2_addr_setup", mfi_mem_addr, 32'h1000_1DE5);
        step();
        chk("t2_hit", {31'd0, check_hit}, 32'd1);
        chk("t2_nofail", {31'd0, check_fail}, 32'd0);

        // 3: wrong dest_addr sets fail, which stays set
        put_ld(4'd0, 4'd6, 16'h0DEE, 32'h1000_0FF7, 32'h0, 32'd4);
        mfi_dest_addr = 4'd6;
        step();
        chk("t3_fail", {31'd0, check_fail}, 32'd1);
        idle_mfi();
        step(); step();
        chk("t3_sticky", {31'd0, check_fail}, 32'd1);

        // 3b: wrong next PC
        do_reset(1);
        put_ld(4'd0, 4'd6, 16'h0DEE, 32'h1000_0FF7, 32'h0, 32'd0);
        mfi_pc_wdata = 32'd8;
        step();
        chk("t3b_fail", {31'd0, check_fail}, 32'd1);

        // 4: negative offset wraps below zero
        do_reset(1);
        put_ld(4'd1, 4'd2, 16'hFFFC, 32'h0000_0002, 32'h1234_5678, 32'h100);
        chk("t4_addr_setup", mfi_mem_addr, 32'hFFFF_FFFE);
        step();
        chk("t4_hit", {31'd0, check_hit}, 32'd1);
        chk("t4_nofail", {31'd0, check_fail}, 32'd0);

        // 5: trapped LD and LD past the check window are ignored
        do_reset(1);
        put_ld(4'd0, 4'd6, 16'h0DEE, 32'h1000_0FF7, 32'h0, 32'd0);
        mfi_trap = 1; mfi_dest_addr = 4'd6;
        step();
        chk("t5_trap_nohit", {31'd0, check_hit}, 32'd0);
        idle_mfi();
        while (m_cycle < 21) step();
        put_ld(4'd0, 4'd6, 16'h0DEE, 32'h1000_0FF7, 32'h0, 32'd0);
        mfi_dest_addr = 4'd6;
        step();
        chk("t5_late_nohit", {31'd0, check_hit}, 32'd0);
        chk("t5_late_nofail", {31'd0, check_fail}, 32'd0);

        // 6: fail then reset; a retirement during reset is not checked
        do_reset(1);
        put_ld(4'd3, 4'd4, 16'h0010, 32'h2000, 32'h55, 32'd0);
        mfi_src1_addr = 4'd5;
        step();
        chk("t6_fail", {31'd0, check_fail}, 32'd1);
        reset_n = 0;
        step();
        chk("t6_fail_clr", {31'd0, check_fail}, 32'd0);
        chk("t6_hit_clr", {31'd0, check_hit}, 32'd0);
        chk("t6_cycle_clr", {24'd0, cycle_reg}, 32'd0);
        reset_n = 1; order_ctr = 0;
        idle_mfi();

        // Randomized retirement traffic in short episodes around the check window
        for (int ep = 0; ep < 40; ep++) begin
            do_reset(1);
            for (int c = 0; c < 25; c++) begin
                inst_valid = 1'($urandom); inst = $urandom;
                idle_mfi();
                if ($urandom_range(0, 9) < 6) begin
                    put_ld(4'($urandom), 4'($urandom), 16'($urandom), $urandom, $urandom,
                           {$urandom_range(0, 1023), 2'b00});
                    if ($urandom_range(0, 9) < 3) mfi_inst[31:28] = 4'($urandom);
                    if ($urandom_range(0, 9) == 0) mfi_trap = 1;
                    if ($urandom_range(0, 9) == 0) mfi_valid = 0;
                    if ($urandom_range(0, 99) < 15) begin
                        order_ctr = order_ctr - 1;
                        mfi_order = order_ctr;
                    end
                    if ($urandom_range(0, 99) < 12) begin
                        case ($urandom_range(0, 4))
                            0: mfi_dest_addr  = mfi_dest_addr ^ 4'($urandom_range(1, 15));
                            1: mfi_src1_addr  = mfi_src1_addr ^ 4'($urandom_range(1, 15));
                            2: mfi_mem_addr   = mfi_mem_addr + 32'($urandom_range(1, 8));
                            3: mfi_dest_wdata = mfi_dest_wdata ^ (32'd1 << $urandom_range(0, 31));
                            default: mfi_pc_wdata = mfi_pc_wdata + 32'd4;
                        endcase
                    end
                end
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
